// File: rtl/ahb_burst_fsm.sv
// ahb_burst_fsm
//   AHB manager-side sequencer for a cached core. It issues uncached single
//   reads/writes and cache-line fetch/writeback bursts, tracks the active data
//   beat and tells the core when it must stall.
//
// Parameters
//   BEATSPERLINE  beats per cache line (4, 8 or 16)
//   BURSTEN       1: line transfers use INCRn with SEQ beats
//                 0: every line beat is its own SINGLE NONSEQ transfer
//
// Ports
//   HCLK          clock, shared with the core
//   reset         synchronous, active-high reset
//   Stall         core pipeline stalled (holds the *_DONE states)
//   Flush         blocks the start of a new transaction
//   BusRW         uncached access request: 10 read, 01 write
//   CacheRW       cache-line request: 10 fetch, 01 writeback
//   HREADY        AHB subordinate ready
//   HTRANS        AHB transfer type (00 IDLE, 10 NONSEQ, 11 SEQ)
//   HWRITE        AHB write
//   HBURST        AHB burst type
//   BeatCount     index of the line beat whose data phase is active
//   CaptureEn     HRDATA is valid for the current beat
//   CacheBusAck   line transfer complete
//   BusStall      bus busy, core must stall
//   BusCommitted  transaction in flight, interrupts not allowed
//
// States
//   ADR_PHASE       | idle; address phase of a new transfer may be issued
//   DATA_PHASE      | data phase of an uncached single transfer
//   DATA_DONE       | single transfer finished, waiting for Stall to drop
//   CACHE_FETCH     | line fill beats in flight
//   CACHE_WRITEBACK | line writeback beats in flight
//   CACHE_DONE      | line transfer finished, waiting for Stall to drop

module ahb_burst_fsm #(
    parameter int BEATSPERLINE = 4,
    parameter bit BURSTEN      = 1'b1,
    localparam int LOGBEATS    = $clog2(BEATSPERLINE)
) (
    input  logic                HCLK,
    input  logic                reset,
    input  logic                Stall,
    input  logic                Flush,
    input  logic [1:0]          BusRW,
    input  logic [1:0]          CacheRW,
    input  logic                HREADY,
    output logic [1:0]          HTRANS,
    output logic                HWRITE,
    output logic [2:0]          HBURST,
    output logic [LOGBEATS-1:0] BeatCount,
    output logic                CaptureEn,
    output logic                CacheBusAck,
    output logic                BusStall,
    output logic                BusCommitted
);

    typedef enum logic [2:0] {
        ADR_PHASE,
        DATA_PHASE,
        DATA_DONE,
        CACHE_FETCH,
        CACHE_WRITEBACK,
        CACHE_DONE
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    // INCR4 / INCR8 / INCR16
    localparam logic [2:0] BURST_LINE = (BEATSPERLINE == 16) ? 3'b111 :
                                        (BEATSPERLINE == 8)  ? 3'b101 : 3'b011;
    localparam logic [LOGBEATS-1:0] LAST_BEAT = LOGBEATS'(BEATSPERLINE - 1);

    state_t              state_q, state_d;
    logic [LOGBEATS-1:0] beat_count_q, beat_count_d;

    logic bus_req;
    logic cache_req;
    logic in_cache;
    logic last_beat;

    assign bus_req   = |BusRW;
    assign cache_req = |CacheRW;
    assign in_cache  = (state_q == CACHE_FETCH) || (state_q == CACHE_WRITEBACK);
    assign last_beat = (beat_count_q == LAST_BEAT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ADR_PHASE: begin
                // Flush only acts here: once a transfer is on the bus it must finish.
                if (HREADY && !Flush) begin
                    if (bus_req)                 state_d = DATA_PHASE;
                    else if (CacheRW == 2'b10)   state_d = CACHE_FETCH;
                    else if (CacheRW == 2'b01)   state_d = CACHE_WRITEBACK;
                end
            end
            DATA_PHASE: begin
                if (HREADY) state_d = DATA_DONE;
            end
            CACHE_FETCH, CACHE_WRITEBACK: begin
                if (HREADY && last_beat) state_d = CACHE_DONE;
            end
            DATA_DONE, CACHE_DONE: begin
                if (!Stall) state_d = ADR_PHASE;
            end
            default: state_d = ADR_PHASE;
        endcase
    end

    // The increment out of the last beat coincides with leaving the cache
    // state, so the counter is cleared there instead of wrapping.
    always_comb begin
        beat_count_d = '0;
        if (in_cache) begin
            if (!HREADY)        beat_count_d = beat_count_q;
            else if (!last_beat) beat_count_d = beat_count_q + LOGBEATS'(1);
        end
    end

    always_ff @(posedge HCLK) begin
        if (reset) begin
            state_q      <= ADR_PHASE;
            beat_count_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_count_q <= beat_count_d;
        end
    end

    always_comb begin
        HTRANS = TRANS_IDLE;
        HWRITE = 1'b0;
        HBURST = 3'b000;
        case (state_q)
            ADR_PHASE: begin
                if (HREADY && (bus_req || cache_req) && !Flush) HTRANS = TRANS_NONSEQ;
                HWRITE = bus_req ? BusRW[0] : CacheRW[0];
                if (BURSTEN && !bus_req && cache_req) HBURST = BURST_LINE;
            end
            DATA_PHASE: begin
                HWRITE = BusRW[0];
            end
            CACHE_FETCH, CACHE_WRITEBACK: begin
                // In beat k's data phase the address of beat k+1 is issued;
                // the last data beat has no further address.
                if (!last_beat) HTRANS = BURSTEN ? TRANS_SEQ : TRANS_NONSEQ;
                HWRITE = (state_q == CACHE_WRITEBACK);
                if (BURSTEN) HBURST = BURST_LINE;
            end
            default: ;
        endcase
    end

    assign BeatCount    = beat_count_q;
    assign CaptureEn    = HREADY && ((state_q == DATA_PHASE) || (state_q == CACHE_FETCH));
    assign CacheBusAck  = (state_q == CACHE_DONE);
    assign BusStall     = ((state_q == ADR_PHASE) && (bus_req || cache_req)) ||
                          (state_q == DATA_PHASE) || in_cache;
    assign BusCommitted = (state_q != ADR_PHASE);

endmodule

// File: tb/tb_ahb_burst_fsm.sv
// Bench for ahb_burst_fsm: three instances (4 beats INCR, 8 beats singles,
// 16 beats INCR) share one stimulus stream and are compared every cycle
// against a transaction-level reference model.
module tb_ahb_burst_fsm;

    logic       HCLK = 1'b0;
    logic       reset = 1'b1;
    logic       Stall = 1'b0;
    logic       Flush = 1'b0;
    logic       HREADY = 1'b1;
    logic [1:0] BusRW = 2'b00;
    logic [1:0] CacheRW = 2'b00;

    always #5 HCLK = ~HCLK;

    logic [1:0] htrans_w[3];
    logic       hwrite_w[3];
    logic [2:0] hburst_w[3];
    logic       cap_w[3];
    logic       ack_w[3];
    logic       stall_w[3];
    logic       comm_w[3];
    logic [1:0] bc0;
    logic [2:0] bc1;
    logic [3:0] bc2;
    logic [3:0] bc_w[3];

    assign bc_w[0] = {2'b00, bc0};
    assign bc_w[1] = {1'b0, bc1};
    assign bc_w[2] = bc2;

    ahb_burst_fsm #(.BEATSPERLINE(4), .BURSTEN(1'b1)) u_dut0 (
        .HCLK(HCLK), .reset(reset), .Stall(Stall), .Flush(Flush), .BusRW(BusRW),
        .CacheRW(CacheRW), .HREADY(HREADY), .HTRANS(htrans_w[0]), .HWRITE(hwrite_w[0]),
        .HBURST(hburst_w[0]), .BeatCount(bc0), .CaptureEn(cap_w[0]),
        .CacheBusAck(ack_w[0]), .BusStall(stall_w[0]), .BusCommitted(comm_w[0]));

    ahb_burst_fsm #(.BEATSPERLINE(8), .BURSTEN(1'b0)) u_dut1 (
        .HCLK(HCLK), .reset(reset), .Stall(Stall), .Flush(Flush), .BusRW(BusRW),
        .CacheRW(CacheRW), .HREADY(HREADY), .HTRANS(htrans_w[1]), .HWRITE(hwrite_w[1]),
        .HBURST(hburst_w[1]), .BeatCount(bc1), .CaptureEn(cap_w[1]),
        .CacheBusAck(ack_w[1]), .BusStall(stall_w[1]), .BusCommitted(comm_w[1]));

    ahb_burst_fsm #(.BEATSPERLINE(16), .BURSTEN(1'b1)) u_dut2 (
        .HCLK(HCLK), .reset(reset), .Stall(Stall), .Flush(Flush), .BusRW(BusRW),
        .CacheRW(CacheRW), .HREADY(HREADY), .HTRANS(htrans_w[2]), .HWRITE(hwrite_w[2]),
        .HBURST(hburst_w[2]), .BeatCount(bc2), .CaptureEn(cap_w[2]),
        .CacheBusAck(ack_w[2]), .BusStall(stall_w[2]), .BusCommitted(comm_w[2]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int burst_code(input int beats);
        return 2 * $clog2(beats) - 1;
    endfunction

    // Reference model: what transaction each instance is serving.
    localparam int K_NONE   = 0;
    localparam int K_SINGLE = 1;
    localparam int K_LINE   = 2;

    int beats_of[3] = '{4, 8, 16};
    bit burst_of[3] = '{1'b1, 1'b0, 1'b1};

    int kind[3]  = '{K_NONE, K_NONE, K_NONE};
    int left[3]  = '{0, 0, 0};
    bit wr[3]    = '{1'b0, 1'b0, 1'b0};
    bit done[3]  = '{1'b0, 1'b0, 1'b0};
    bit known    = 1'b0;

    int issued[3];
    int captures[3];
    int acks[3];
    int beat3_cycles[3];

    task automatic clear_counters();
        for (int i = 0; i < 3; i++) begin
            issued[i] = 0; captures[i] = 0; acks[i] = 0; beat3_cycles[i] = 0;
        end
    endtask

    always @(negedge HCLK) begin
        for (int i = 0; i < 3; i++) begin
            int e_ht, e_hb, e_cap, e_ack, e_stall, e_comm, e_beat, e_hw;
            bit chk_hw, chk_hb, rq_b, rq_c;
            rq_b = (BusRW != 2'b00);
            rq_c = (CacheRW != 2'b00);
            e_ht = 0; e_hb = 0; e_cap = 0; e_ack = 0; e_stall = 0; e_comm = 1;
            e_beat = 0; e_hw = 0; chk_hw = 1'b1; chk_hb = 1'b1;
            if (kind[i] == K_NONE) begin
                e_ht    = (HREADY && (rq_b || rq_c) && !Flush) ? 2 : 0;
                e_hw    = rq_b ? int'(BusRW[0]) : int'(CacheRW[0]);
                e_hb    = (burst_of[i] && !rq_b && rq_c) ? burst_code(beats_of[i]) : 0;
                e_stall = int'(rq_b || rq_c);
                e_comm  = 0;
            end else if (done[i]) begin
                e_ack  = int'(kind[i] == K_LINE);
                chk_hw = 1'b0;
                chk_hb = 1'b0;
            end else if (kind[i] == K_SINGLE) begin
                e_hw    = int'(BusRW[0]);
                e_cap   = int'(HREADY);
                e_stall = 1;
            end else begin
                e_beat  = beats_of[i] - left[i];
                e_ht    = (left[i] > 1) ? (burst_of[i] ? 3 : 2) : 0;
                e_hw    = int'(wr[i]);
                e_hb    = burst_of[i] ? burst_code(beats_of[i]) : 0;
                e_cap   = int'(HREADY && !wr[i]);
                e_stall = 1;
            end
            if (known) begin
                check_val($sformatf("htrans[%0d]", i), 32'(htrans_w[i]), e_ht);
                if (chk_hw) check_val($sformatf("hwrite[%0d]", i), 32'(hwrite_w[i]), e_hw);
                if (chk_hb) check_val($sformatf("hburst[%0d]", i), 32'(hburst_w[i]), e_hb);
                check_val($sformatf("beat[%0d]", i), 32'(bc_w[i]), e_beat);
                check_val($sformatf("capture[%0d]", i), 32'(cap_w[i]), e_cap);
                check_val($sformatf("ack[%0d]", i), 32'(ack_w[i]), e_ack);
                check_val($sformatf("busstall[%0d]", i), 32'(stall_w[i]), e_stall);
                check_val($sformatf("committed[%0d]", i), 32'(comm_w[i]), e_comm);
            end
            if (htrans_w[i] != 2'b00 && HREADY) issued[i]++;
            if (cap_w[i]) captures[i]++;
            if (ack_w[i]) acks[i]++;
            if (bc_w[i] == 4'd3) beat3_cycles[i]++;
        end
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                kind[i] = K_NONE; done[i] = 1'b0;
            end else if (kind[i] == K_NONE) begin
                if (HREADY && !Flush) begin
                    if (BusRW != 2'b00) begin
                        kind[i] = K_SINGLE; done[i] = 1'b0;
                    end else if (CacheRW == 2'b10 || CacheRW == 2'b01) begin
                        kind[i] = K_LINE; left[i] = beats_of[i];
                        wr[i] = (CacheRW == 2'b01); done[i] = 1'b0;
                    end
                end
            end else if (done[i]) begin
                if (!Stall) begin kind[i] = K_NONE; done[i] = 1'b0; end
            end else if (kind[i] == K_SINGLE) begin
                if (HREADY) done[i] = 1'b1;
            end else if (HREADY) begin
                left[i]--;
                if (left[i] == 0) done[i] = 1'b1;
            end
        end
        if (reset) known = 1'b1;
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic wait_beat(input int inst, input int beat, input string tag);
        int k;
        k = 0;
        while (bc_w[inst] != 4'(beat) && k < 40) begin
            step();
            k++;
        end
        if (k >= 40) check_val(tag, 32'(bc_w[inst]), beat);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 400000", $time);
        $fatal(1);
    end

    initial begin
        clear_counters();
        step(); step();
        #2;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("rst_htrans[%0d]", i), 32'(htrans_w[i]), 0);
            check_val($sformatf("rst_hburst[%0d]", i), 32'(hburst_w[i]), 0);
            check_val($sformatf("rst_stall[%0d]", i), 32'(stall_w[i]), 0);
            check_val($sformatf("rst_comm[%0d]", i), 32'(comm_w[i]), 0);
            check_val($sformatf("rst_ack[%0d]", i), 32'(ack_w[i]), 0);
            check_val($sformatf("rst_beat[%0d]", i), 32'(bc_w[i]), 0);
        end
        step();
        reset = 1'b0;
        step();

        // Single read
        BusRW = 2'b10;
        #2;
        check_val("rd_c0_htrans", 32'(htrans_w[0]), 2);
        check_val("rd_c0_hwrite", 32'(hwrite_w[0]), 0);
        check_val("rd_c0_hburst", 32'(hburst_w[0]), 0);
        step();
        BusRW = 2'b00;
        #2;
        check_val("rd_c1_capture", 32'(cap_w[0]), 1);
        step(); #2;
        check_val("rd_c2_busstall", 32'(stall_w[0]), 0);
        check_val("rd_c2_committed", 32'(comm_w[0]), 1);
        step(); #2;
        check_val("rd_c3_committed", 32'(comm_w[0]), 0);
        step();

        // Line fill
        clear_counters();
        CacheRW = 2'b10;
        #2;
        check_val("fill_c0_htrans", 32'(htrans_w[0]), 2);
        check_val("fill_c0_hburst", 32'(hburst_w[0]), 3);
        step();
        CacheRW = 2'b00;
        for (int k = 0; k < 4; k++) begin
            #2;
            check_val($sformatf("fill_htrans_b%0d", k), 32'(htrans_w[0]), (k < 3) ? 2'b11 : 2'b00);
            check_val($sformatf("fill_beat_b%0d", k), 32'(bc_w[0]), k);
            step();
        end
        #2;
        check_val("fill_ack", 32'(ack_w[0]), 1);
        repeat (20) step();
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("fill_captures[%0d]", i), captures[i], beats_of[i]);
            check_val($sformatf("fill_acks[%0d]", i), acks[i], 1);
        end

        // Writeback with HREADY low at beat 3
        clear_counters();
        CacheRW = 2'b01;
        step();
        CacheRW = 2'b00;
        wait_beat(1, 3, "wb_wait_beat3");
        HREADY = 1'b0;
        step(); step();
        HREADY = 1'b1;
        repeat (25) step();
        check_val("wb_issued[1]", issued[1], 8);
        check_val("wb_beat3_cycles[1]", beat3_cycles[1], 3);
        check_val("wb_captures[1]", captures[1], 0);
        for (int i = 0; i < 3; i++)
            check_val($sformatf("wb_acks[%0d]", i), acks[i], 1);
        check_val("wb_issued[2]", issued[2], 16);

        // Flush in ADR_PHASE, then flush mid-burst
        Flush = 1'b1;
        BusRW = 2'b01;
        #2;
        check_val("flush_adr_htrans", 32'(htrans_w[0]), 0);
        step();
        #2;
        check_val("flush_adr_committed", 32'(comm_w[0]), 0);
        Flush = 1'b0;
        BusRW = 2'b00;
        step();
        clear_counters();
        CacheRW = 2'b10;
        step();
        CacheRW = 2'b00;
        wait_beat(0, 1, "flush_wait_beat1");
        Flush = 1'b1;
        repeat (25) step();
        Flush = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("flush_captures[%0d]", i), captures[i], beats_of[i]);
            check_val($sformatf("flush_acks[%0d]", i), acks[i], 1);
        end

        // Simultaneous single and line requests
        clear_counters();
        BusRW = 2'b10;
        CacheRW = 2'b10;
        #2;
        check_val("both_c0_hburst", 32'(hburst_w[0]), 0);
        step();
        BusRW = 2'b00;
        step(); step();
        #2;
        check_val("both_c3_htrans", 32'(htrans_w[0]), 2);
        check_val("both_c3_hburst", 32'(hburst_w[0]), 3);
        step();
        CacheRW = 2'b00;
        repeat (25) step();
        check_val("both_acks[0]", acks[0], 1);
        check_val("both_captures[0]", captures[0], 1 + 4);

        // Reset in the middle of a writeback
        CacheRW = 2'b01;
        step();
        CacheRW = 2'b00;
        wait_beat(0, 2, "rst_wait_beat2");
        reset = 1'b1;
        step();
        reset = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("midrst_committed[%0d]", i), 32'(comm_w[i]), 0);
            check_val($sformatf("midrst_beat[%0d]", i), 32'(bc_w[i]), 0);
            check_val($sformatf("midrst_htrans[%0d]", i), 32'(htrans_w[i]), 0);
        end
        step();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 15);
            BusRW = (r == 0) ? 2'b10 : (r == 1) ? 2'b01 : 2'b00;
            r = $urandom_range(0, 7);
            CacheRW = (r == 0) ? 2'b10 : (r == 1) ? 2'b01 : 2'b00;
            HREADY = ($urandom_range(0, 3) != 0);
            Stall = ($urandom_range(0, 3) == 0);
            Flush = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        BusRW = 2'b00; CacheRW = 2'b00; HREADY = 1'b1;
        Stall = 1'b0; Flush = 1'b0; reset = 1'b0;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
